period_loader: RTL and testbench

Serial configuration front-end for the frequency counter: it receives a 16-bit command frame over a 3-wire serial link (`cs_n`, `sclk`, `sdata`) that is asynchronous to `clk`. It validates the frame and presents a new counting-window length on `period` with a one-cycle `period_load` strobe. It sits directly upstream of the counter and drives its `period` / `period_load` inputs; malformed frames are rejected and flagged on `frame_err`.

---
 rtl/period_loader.sv | 199 +++++++++++++++++++
 tb/tb_period_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/period_loader.sv
// period_loader: serial configuration front-end for the frequency counter.
// It receives a 16-bit command frame over an asynchronous cs_n/sclk/sdata
// link, validates it and presents a new counting-window length on period
// together with a one-cycle period_load strobe. Rejected frames pulse
// frame_err and leave period untouched.
module period_loader #(
  parameter int BITS           = 12,
  parameter int DEFAULT_PERIOD = 1200,
  parameter int MIN_PERIOD     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs_n,
  input  logic            sclk,
  input  logic            sdata,
  output logic [BITS-1:0] period,
  output logic            period_load,
  output logic            frame_err,
  output logic            busy
);

  localparam int          CMD_BITS    = 4;
  localparam int          FRAME_BITS  = CMD_BITS + BITS;
  localparam logic [3:0]  CMD_LOAD    = 4'hA;
  localparam logic [3:0]  CMD_DEFAULT = 4'h5;
  localparam logic [4:0]  CNT_FULL    = 5'(FRAME_BITS);
  localparam logic [4:0]  CNT_SAT     = 5'(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_CHECK     = 3'd2,
    ST_LOAD      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;

  logic                    cs_meta_r, cs_sync_r, cs_prev_r;
  logic                    sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic                    sdata_meta_r, sdata_sync_r;
  logic [1:0]              settle_r;
  logic [FRAME_BITS-1:0]   shift_r;
  logic [4:0]              bit_cnt_r;

  logic                    cs_fall_s, cs_rise_s, sclk_rise_s, settle_done_s;
  logic                    shift_clr_s, shift_en_s;
  logic [CMD_BITS-1:0]     cmd_s;
  logic [BITS-1:0]         data_s;
  logic                    frame_ok_s;
  logic                    load_s, err_s;
  logic [BITS-1:0]         load_value_s;

  // Two-flop synchronisers plus a third stage on cs_n and sclk for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta_r    <= 1'b1;
      cs_sync_r    <= 1'b1;
      cs_prev_r    <= 1'b1;
      sclk_meta_r  <= 1'b0;
      sclk_sync_r  <= 1'b0;
      sclk_prev_r  <= 1'b0;
      sdata_meta_r <= 1'b1;
      sdata_sync_r <= 1'b1;
    end else begin
      cs_meta_r    <= cs_n;
      cs_sync_r    <= cs_meta_r;
      cs_prev_r    <= cs_sync_r;
      sclk_meta_r  <= sclk;
      sclk_sync_r  <= sclk_meta_r;
      sclk_prev_r  <= sclk_sync_r;
      sdata_meta_r <= sdata;
      sdata_sync_r <= sdata_meta_r;
    end
  end

  // Settle counter: the synchroniser reset values are not real samples, so the
  // post-reset wait must not trust cs_n until the pipeline holds pin data.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_r <= 2'd0;
    end else if (settle_r != 2'd3) begin
      settle_r <= settle_r + 2'd1;
    end else begin
      settle_r <= settle_r;
    end
  end

  assign cs_fall_s     = cs_prev_r & ~cs_sync_r;
  assign cs_rise_s     = ~cs_prev_r & cs_sync_r;
  assign sclk_rise_s   = ~sclk_prev_r & sclk_sync_r;
  assign settle_done_s = (settle_r == 2'd3);

  assign cmd_s  = shift_r[FRAME_BITS-1 -: CMD_BITS];
  assign data_s = shift_r[BITS-1:0];

  assign frame_ok_s   = (bit_cnt_r == CNT_FULL) &&
                        (((cmd_s == CMD_LOAD) && (data_s >= BITS'(MIN_PERIOD))) ||
                         (cmd_s == CMD_DEFAULT));
  assign load_value_s = (cmd_s == CMD_LOAD) ? data_s : BITS'(DEFAULT_PERIOD);
  assign load_s       = (state_r == ST_CHECK) && frame_ok_s;
  assign err_s        = (state_r == ST_CHECK) && !frame_ok_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_WAIT_HIGH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; a cs_n rise takes priority over a coincident sclk rise.
  always_comb begin
    next_state_s = state_r;
    shift_clr_s  = 1'b0;
    shift_en_s   = 1'b0;
    case (state_r)
      ST_WAIT_HIGH: begin
        if (settle_done_s && cs_sync_r) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WAIT_HIGH;
        end
      end
      ST_IDLE: begin
        if (cs_fall_s) begin
          shift_clr_s  = 1'b1;
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_s) begin
          next_state_s = ST_CHECK;
        end else if (sclk_rise_s) begin
          shift_en_s   = 1'b1;
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_CHECK: begin
        if (frame_ok_s) begin
          next_state_s = ST_LOAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Frame shift register and saturating bit counter (17 means overflow).
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r   <= '0;
      bit_cnt_r <= 5'd0;
    end else if (shift_clr_s) begin
      shift_r   <= '0;
      bit_cnt_r <= 5'd0;
    end else if (shift_en_s) begin
      shift_r   <= {shift_r[FRAME_BITS-2:0], sdata_sync_r};
      bit_cnt_r <= (bit_cnt_r == CNT_SAT) ? bit_cnt_r : bit_cnt_r + 5'd1;
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Registered outputs; strobes are issued on the CHECK decision edge so they
  // are high while the FSM sits in LOAD (or back in IDLE for an error).
  always_ff @(posedge clk) begin
    if (reset) begin
      period      <= BITS'(DEFAULT_PERIOD);
      period_load <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      period_load <= load_s;
      frame_err   <= err_s;
      busy        <= (next_state_s == ST_SHIFT) || (next_state_s == ST_CHECK) ||
                     (next_state_s == ST_LOAD);
      if (load_s) begin
        period <= load_value_s;
      end else begin
        period <= period;
      end
    end
  end

endmodule

// File: tb/tb_period_loader.sv
// Self-checking bench for period_loader: a hand-written vector table, a few
// multi-cycle corner sequences and randomized frames against a frame-level model.
module tb_period_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n;
  logic        sclk;
  logic        sdata;
  logic [11:0] period;
  logic        period_load;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cur_period;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    bit          exp_load;
    bit          exp_err;
    int          exp_period;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  period_loader #(.BITS(12), .DEFAULT_PERIOD(1200), .MIN_PERIOD(16)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sclk(sclk), .sdata(sdata),
    .period(period), .period_load(period_load), .frame_err(frame_err), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Frame-level reference: decide outcome from the frame contents and length.
  function automatic void ref_model(input logic [31:0] w, input int n, input int cur,
                                    output bit el, output bit ee, output int np);
    int cmd;
    int data;
    cmd  = int'(w[15:12]);
    data = int'(w[11:0]);
    el = 1'b0; ee = 1'b1; np = cur;
    if (n == 16 && cmd == 10 && data >= 16) begin
      el = 1'b1; ee = 1'b0; np = data;
    end else if (n == 16 && cmd == 5) begin
      el = 1'b1; ee = 1'b0; np = 1200;
    end
  endfunction

  task automatic start_frame();
    @(negedge clk);
    cs_n = 1'b0;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      sclk  = 1'b0;
      sdata = w[i];
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Called right after cs_n is released at a falling edge; cycle 0 is edge k.
  task automatic monitor(input bit el, input bit ee, input int ep, input string tag);
    int lc = 0;
    int ec = 0;
    int lat = -1;
    int eat = -1;
    logic [11:0] pat = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (period_load === 1'b1) begin lc++; lat = i; pat = period; end
      if (frame_err === 1'b1) begin ec++; eat = i; end
    end
    check({tag, "_load_count"}, lc, {31'd0, el});
    check({tag, "_err_count"}, ec, {31'd0, ee});
    if (el) begin
      check({tag, "_load_latency"}, lat, 32'd3);
      check({tag, "_period_at_load"}, pat, ep);
    end
    if (ee) check({tag, "_err_latency"}, eat, 32'd3);
    check({tag, "_period"}, period, ep);
    check({tag, "_busy_after"}, busy, 32'd0);
  endtask

  task automatic run_frame(input logic [31:0] w, input int n, input bit el, input bit ee,
                           input int ep, input string tag);
    start_frame();
    send_bits(w, n);
    check({tag, "_busy_in_frame"}, busy, 32'd1);
    @(negedge clk);
    cs_n = 1'b1;
    monitor(el, ee, ep, tag);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int lc;
    int ec;
    logic [31:0] w;
    int n;
    bit el;
    bit ee;
    int np;

    vecs[0]  = '{32'h0000_A064, 16, 1'b1, 1'b0, 100};
    vecs[1]  = '{32'h0000_5123, 16, 1'b1, 1'b0, 1200};
    vecs[2]  = '{32'h0000_A064, 16, 1'b1, 1'b0, 100};
    vecs[3]  = '{32'h0000_A00F, 16, 1'b0, 1'b1, 100};
    vecs[4]  = '{32'h0000_3100, 16, 1'b0, 1'b1, 100};
    vecs[5]  = '{32'h0000_5032, 15, 1'b0, 1'b1, 100};
    vecs[6]  = '{32'h0001_40C8, 17, 1'b0, 1'b1, 100};
    vecs[7]  = '{32'h0000_0000, 0,  1'b0, 1'b1, 100};
    vecs[8]  = '{32'h0000_A010, 16, 1'b1, 1'b0, 16};
    vecs[9]  = '{32'h0000_AFFF, 16, 1'b1, 1'b0, 4095};
    vecs[10] = '{32'h0000_5000, 16, 1'b1, 1'b0, 1200};

    reset = 1'b1;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    sdata = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: no strobes, default period.
    lc = 0;
    ec = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (period_load === 1'b1) lc++;
      if (frame_err === 1'b1) ec++;
    end
    check("reset_period", period, 32'd1200);
    check("reset_busy", busy, 32'd0);
    check("reset_load_count", lc, 32'd0);
    check("reset_err_count", ec, 32'd0);

    for (int v = 0; v < 11; v++) begin
      run_frame(vecs[v].word, vecs[v].nbits, vecs[v].exp_load, vecs[v].exp_err,
                vecs[v].exp_period, $sformatf("vec%0d", v));
    end
    cur_period = 1200;

    // cs_n rise coincident with the 16th sclk rise: that edge is discarded.
    start_frame();
    send_bits(32'h0000_A064 >> 1, 15);
    @(negedge clk);
    sclk  = 1'b0;
    sdata = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    cs_n = 1'b1;
    monitor(1'b0, 1'b1, cur_period, "coincident");
    sclk = 1'b0;
    repeat (8) @(negedge clk);

    // Reset in the middle of a frame, then the remainder of that frame.
    start_frame();
    send_bits(32'h0000_00A2, 8);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_period", period, 32'd1200);
    check("midreset_load", period_load, 32'd0);
    check("midreset_err", frame_err, 32'd0);
    check("midreset_busy", busy, 32'd0);
    reset = 1'b0;
    send_bits(32'h0000_0000, 8);
    check("midreset_busy_wait", busy, 32'd0);
    @(negedge clk);
    cs_n = 1'b1;
    monitor(1'b0, 1'b0, 1200, "midreset_release");
    repeat (8) @(negedge clk);
    run_frame(32'h0000_A200, 16, 1'b1, 1'b0, 512, "after_midreset");
    cur_period = 512;

    // Randomized frames against the frame-level model.
    for (int r = 0; r < 20; r++) begin
      int sel;
      logic [3:0]  cmd;
      logic [11:0] data;
      sel = int'($urandom_range(0, 9));
      if (sel < 4) cmd = 4'hA;
      else if (sel < 7) cmd = 4'h5;
      else cmd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) data = 12'($urandom_range(0, 31));
      else data = 12'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 7) n = 16;
      else if (sel == 7) n = 15;
      else if (sel == 8) n = 17;
      else n = int'($urandom_range(0, 14));
      w = $urandom;
      w[15:0] = {cmd, data};
      ref_model(w, n, cur_period, el, ee, np);
      run_frame(w, n, el, ee, np, $sformatf("rand%0d", r));
      cur_period = np;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
